// File: rtl/serial_subtractor16.sv
// serial_subtractor16: multicycle two's-complement subtractor z = x - y.
// Computes x + ~y + 1 one SLICE-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register. It has a start/busy/done
// handshake. It produces the sign, zero, borrow, parity and overflow flags.
module serial_subtractor16 #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             borrow,
    output logic             parity,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_xr;      // latched minuend
    logic [WIDTH-1:0] r_yr;      // latched, inverted subtrahend
    logic             r_carry;   // carry into the current slice
    logic [CNT_W-1:0] r_cnt;     // index of the slice computed on the next edge
    logic [WIDTH-1:0] r_acc;     // partial result, filled slice by slice

    logic [WIDTH-1:0] r_z;
    logic             r_sign;
    logic             r_zero;
    logic             r_borrow;
    logic             r_parity;
    logic             r_overflow;

    logic             w_accept;
    logic             w_last;
    int               w_base;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_result;

    // Handshake decode: operands are taken in IDLE or DONE; RUN ignores start.
    always_comb begin
        w_accept = start && (r_state != S_RUN);
        w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);
        busy     = (r_state == S_RUN);
        done     = (r_state == S_DONE);
    end

    // Slice adder, plus the full result with the current slice merged in.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_base   = int'(r_cnt) * SLICE;
        {w_cout, w_sum} = {1'b0, r_xr[w_base +: SLICE]}
                        + {1'b0, r_yr[w_base +: SLICE]}
                        + {{SLICE{1'b0}}, r_carry};
        w_result = r_acc;
        w_result[w_base +: SLICE] = w_sum;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_RUN;
            S_RUN:   if (w_last)   w_next_state = S_DONE;
            S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand latch, slice counter, carry chain and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all datapath state is cleared on reset. The state is a few
            // flops, not a RAM, so an aborted operation leaves nothing behind.
            r_xr    <= '0;
            r_yr    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_xr    <= x;
            r_yr    <= ~y;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc[w_base +: SLICE] <= w_sum;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result and flag registers, updated only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z        <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_borrow   <= 1'b0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_z        <= w_result;
            r_sign     <= w_result[WIDTH-1];
            r_zero     <= (w_result == '0);
            r_borrow   <= ~w_cout;
            r_parity   <= ~^w_result;
            // r_yr holds ~y, so equal MSBs in r_xr/r_yr mean x and y differ in sign.
            r_overflow <= (r_xr[WIDTH-1] == r_yr[WIDTH-1])
                       && (w_result[WIDTH-1] != r_xr[WIDTH-1]);
        end
    end

    assign z        = r_z;
    assign sign     = r_sign;
    assign zero     = r_zero;
    assign borrow   = r_borrow;
    assign parity   = r_parity;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed testbench for serial_subtractor16. Every expected value is a
// hand-computed constant. The flag vector is ordered {sign, zero, borrow, parity, overflow}.
module tb_serial_subtractor16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        borrow;
    logic        parity;
    logic        overflow;

    int checks;
    int failures;

    logic [20:0] obs;
    assign obs = {z, sign, zero, borrow, parity, overflow};

    serial_subtractor16 #(.WIDTH(16), .SLICE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .z        (z),
        .sign     (sign),
        .zero     (zero),
        .borrow   (borrow),
        .parity   (parity),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This task presents operands at a negedge and drops start one cycle later.
    // It returns at the negedge following the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        x     = a;
        y     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // This task starts at the negedge after the accept edge. It returns at the
    // first negedge where done is high, or when the budget runs out.
    // cycles counts the negedges after that first one. busy_cnt counts the
    // sampled negedges where busy was high.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, obs} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b z/flags=%h, want all 0",
                     busy, done, obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int cyc, bc;
        issue(16'h0005, 16'h0003);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || bc !== 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency: got done_after=%0d busy_cycles=%0d busy_at_done=%b, want 4 4 0",
                     cyc, bc, busy);
        end
        checks++;
        if (obs !== {16'h0002, 5'b00000}) begin
            failures++;
            $display("FAIL basic_5m3: got %h, want %h", obs, {16'h0002, 5'b00000});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || obs !== {16'h0002, 5'b00000}) begin
            failures++;
            $display("FAIL done_pulse_hold: got done=%b z/flags=%h, want done=0 z/flags=%h",
                     done, obs, {16'h0002, 5'b00000});
        end
    endtask

    task automatic test_flags;
        int cyc, bc;
        logic [15:0] va [4] = '{16'h0003, 16'h1234, 16'h8000, 16'h7FFF};
        logic [15:0] vb [4] = '{16'h0005, 16'h1234, 16'h0001, 16'hFFFF};
        logic [20:0] ve [4] = '{{16'hFFFE, 5'b10100}, {16'h0000, 5'b01010},
                                {16'h7FFF, 5'b00001}, {16'h8000, 5'b10101}};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i]);
            wait_done(cyc, bc);
            checks++;
            if (cyc !== 4 || obs !== ve[i]) begin
                failures++;
                $display("FAIL flags_%h_minus_%h: got cycles=%0d z/flags=%h, want 4 %h",
                         va[i], vb[i], cyc, obs, ve[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int          cyc;
        logic [20:0] prev;
        logic        held;
        prev = obs;  // previous result: 0x8000 from 7FFF-FFFF
        held = 1'b1;
        issue(16'h0100, 16'h0001);
        @(negedge clk);          // after E1
        start = 1'b1;
        x     = 16'hFFFF;
        y     = 16'h1234;
        if (obs !== prev) held = 1'b0;
        @(negedge clk);          // after E2
        start = 1'b0;
        x     = 16'h5555;
        y     = 16'hAAAA;
        if (obs !== prev) held = 1'b0;
        @(negedge clk);          // after E3
        if (obs !== prev) held = 1'b0;
        cyc = 3;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!held || prev !== {16'h8000, 5'b10101}) begin
            failures++;
            $display("FAIL hold_during_run: got held=%b prev=%h, want held=1 prev=%h",
                     held, prev, {16'h8000, 5'b10101});
        end
        checks++;
        if (cyc !== 4 || obs !== {16'h00FF, 5'b00010}) begin
            failures++;
            $display("FAIL ignore_start: got cycles=%0d z/flags=%h, want 4 %h",
                     cyc, obs, {16'h00FF, 5'b00010});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL no_restart: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        issue(16'h0009, 16'h0002);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || obs !== {16'h0007, 5'b00000}) begin
            failures++;
            $display("FAIL b2b_first: got cycles=%0d z/flags=%h, want 4 %h",
                     cyc, obs, {16'h0007, 5'b00000});
        end
        // Issue the next operation during the DONE cycle.
        start = 1'b1;
        x     = 16'h0010;
        y     = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_gap: got busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(cyc, bc);
        checks++;
        if (cyc + 1 !== 5 || obs !== {16'h000F, 5'b00010}) begin
            failures++;
            $display("FAIL b2b_second: got done_spacing=%0d z/flags=%h, want 5 %h",
                     cyc + 1, obs, {16'h000F, 5'b00010});
        end
    endtask

    task automatic test_boundaries;
        int cyc, bc;
        issue(16'h0000, 16'h0000);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || obs !== {16'h0000, 5'b01010}) begin
            failures++;
            $display("FAIL zero_minus_zero: got cycles=%0d z/flags=%h, want 4 %h",
                     cyc, obs, {16'h0000, 5'b01010});
        end
        issue(16'h0000, 16'h8000);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || obs !== {16'h8000, 5'b10101}) begin
            failures++;
            $display("FAIL zero_minus_min: got cycles=%0d z/flags=%h, want 4 %h",
                     cyc, obs, {16'h8000, 5'b10101});
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bc;
        issue(16'hFFFF, 16'h0001);
        @(negedge clk);          // second RUN cycle
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, obs} !== 23'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%b done=%b z/flags=%h, want all 0",
                     busy, done, obs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'hA5A5, 16'h5A5A);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || obs !== {16'h4B4B, 5'b00011}) begin
            failures++;
            $display("FAIL after_reset_A5A5: got cycles=%0d z/flags=%h, want 4 %h",
                     cyc, obs, {16'h4B4B, 5'b00011});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_flags();
        test_ignore_start();
        test_back_to_back();
        test_boundaries();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor16.md
Name: serial_subtractor16

Overview:
- Multicycle 16-bit two's-complement subtractor computing z = x - y.
- Processes one SLICE-bit slice per clock, LSB slice first, with a registered borrow/carry chain. This is the subtract-side companion to the team's 16-bit adder.
- Produces the same flag set as the adder (sign, zero, parity, overflow), with carry replaced by borrow.
- Start/busy/done handshake lets a sequencing FSM issue operations and collect results.

Parameters:
- WIDTH, 16, operand/result width.
- SLICE, 4, bits processed per cycle. WIDTH must be an integer multiple of SLICE. Latency N = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; x,y sampled on the edge where start=1 and the block accepts
- x  input  WIDTH  minuend
- y  input  WIDTH  subtrahend
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; z and flags valid and newly updated
- z  output  WIDTH  result x - y mod 2^WIDTH
- sign  output  1  z[WIDTH-1]
- zero  output  1  z == 0
- borrow  output  1  x < y unsigned, i.e. inverted carry-out of x + ~y + 1
- parity  output  1  even-parity flag, ~^z (1 when z has an even count of ones)
- overflow  output  1  signed overflow: x[MSB] != y[MSB] and z[MSB] != x[MSB]

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - busy, done, z and all flags are 0.
  - Slice counter, operand registers and chain register are cleared.
  - Asserting reset mid-operation aborts it with no partial result visible.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start=1 -> latch x into XR and ~y into YR, set chain carry to 1, clear slice counter, go to RUN. start=0 -> stay.
  - RUN: busy=1. Each edge computes slice k = counter from XR, YR and the chain carry:
    - The slice sum goes into internal accumulator ACC[k*SLICE +: SLICE].
    - The slice carry-out goes into the chain register.
    - Counter increments.
    - On the edge completing slice N-1:
      - Load z from the completed ACC.
      - Load all flags, computed from the completed result and the latched operands.
      - Set done=1 and go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 -> accept new operands exactly as in IDLE and go to RUN (back-to-back throughput: one result per N+1 cycles).
    - Otherwise -> IDLE.
- Latency and timing:
  - Accept edge E0; done is high in the cycle after edge E(N), i.e. E4 for default parameters.
  - busy is high from after E0 until E(N).
- Output stability:
  - z and the flags change only on the completing edge (or on reset).
  - They hold their previous result through RUN, IDLE and DONE until the next completion.
- start is ignored while in RUN. x and y are don't-care except on the accept edge; changing them during RUN must not affect the result.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - borrow = ~(final chain carry).
  - overflow uses the latched operand MSBs, not live inputs.
- Boundaries:
  - 0 - 0: z=0, zero=1, parity=1, borrow=0.
  - 0x8000 - 0x0001: overflow=1.
  - 0x0000 - 0x8000: z=0x8000, overflow=1, borrow=1.

Test Plan:
- Reset, then 0x0005 - 0x0003 -> done after E4; z=0x0002, sign=0, zero=0, borrow=0, parity=0, overflow=0; busy high exactly 4 cycles.
- 0x0003 - 0x0005 -> z=0xFFFE, sign=1, borrow=1, parity=0, overflow=0; 0x1234 - 0x1234 -> z=0x0000, zero=1, parity=1, borrow=0.
- 0x8000 - 0x0001 -> z=0x7FFF, overflow=1, sign=0, borrow=0; 0x7FFF - 0xFFFF -> z=0x8000, overflow=1, borrow=1.
- Pulse start during RUN with different x/y, and toggle x/y mid-RUN -> ignored; result still the first operation. z stays at the previous result until completion.
- start held high in the DONE cycle with 0x0010 - 0x0001 -> accepted with no IDLE gap; next done 5 cycles after the previous one; z=0x000F, parity=1.
- rst_n low at cycle 2 of RUN (asynchronous, mid-clock) -> busy, done, z and flags 0 immediately. After release, 0xA5A5 - 0x5A5A completes normally: z=0x4B4B, overflow=1, borrow=0.
